// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared constants and state encoding for the port arbiter
package cpu_ctrl_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick with optional single-index exclusion
module rr_pick
  import cpu_ctrl_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             excl_en,
  input  logic [SEL_W-1:0] excl_idx,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  // Scan from ptr upward (mod 4); the first eligible set bit wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[ptr + SEL_W'(k)] &&
          !(excl_en && ((ptr + SEL_W'(k)) == excl_idx))) begin
        found = 1'b1;
        idx   = ptr + SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// rtl/rf_port_arbiter.sv - round-robin arbiter for the shared register-file write-address port
module rf_port_arbiter
  import cpu_ctrl_pkg::*;
#(
  parameter int W        = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     addr0,
  input  logic [W-1:0]     addr1,
  input  logic [W-1:0]     addr2,
  input  logic [W-1:0]     addr3,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic [W-1:0]     addr_o
);

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  arb_state_t       state, state_n;
  logic [SEL_W-1:0] owner, owner_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [3:0]       hold_cnt, hold_n;

  logic             excl_en;
  logic             found;
  logic [SEL_W-1:0] idx;
  logic             owner_req;
  logic             timeout;

  assign owner_req = req[owner];
  assign timeout   = (hold_cnt >= MAX_HOLD_C);
  // Only a timed-out owner that still wants the port is kept out of the scan.
  assign excl_en   = (state == ARB_GRANT) && owner_req && timeout;

  rr_pick u_pick (
    .req      (req),
    .ptr      (ptr),
    .excl_en  (excl_en),
    .excl_idx (owner),
    .found    (found),
    .idx      (idx)
  );

  // Next-state, ownership, pointer and tenure counter.
  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    case (state)
      ARB_IDLE: begin
        if (found) begin
          state_n = ARB_GRANT;
          owner_n = idx;
          ptr_n   = idx + SEL_W'(1);
          hold_n  = 4'd1;
        end
      end
      ARB_GRANT: begin
        if (owner_req && !timeout) begin
          hold_n = hold_cnt + 4'd1;
        end else if (owner_req) begin
          // Timeout: rotate if anyone else waits, otherwise restart the tenure.
          hold_n = 4'd1;
          if (found) begin
            owner_n = idx;
            ptr_n   = idx + SEL_W'(1);
          end
        end else if (found) begin
          owner_n = idx;
          ptr_n   = idx + SEL_W'(1);
          hold_n  = 4'd1;
        end else begin
          state_n = ARB_IDLE;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  // State and registered outputs; sel keeps its last value while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      sel      <= '0;
      valid    <= 1'b0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      valid    <= (state_n == ARB_GRANT);
      if (state_n == ARB_GRANT) begin
        gnt <= N_REQ'(1) << owner_n;
        sel <= owner_n;
      end else begin
        gnt <= '0;
      end
    end
  end

  // Drive the selected requester's address onto the shared port.
  always_comb begin
    case (sel)
      2'd0:    addr_o = addr0;
      2'd1:    addr_o = addr1;
      2'd2:    addr_o = addr2;
      default: addr_o = addr3;
    endcase
  end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// tb/tb_rf_port_arbiter.sv - directed self-checking bench for rf_port_arbiter
module tb_rf_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [2:0] addr0, addr1, addr2, addr3;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic [2:0] addr_o;

  int tests = 0;
  int fails = 0;

  rf_port_arbiter #(.W(3), .MAX_HOLD(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .addr0  (addr0),
    .addr1  (addr1),
    .addr2  (addr2),
    .addr3  (addr3),
    .gnt    (gnt),
    .sel    (sel),
    .valid  (valid),
    .addr_o (addr_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] e;
    rst = 1'b1; req = 4'b0000;
    addr0 = 3'd2; addr1 = 3'd5; addr2 = 3'd6; addr3 = 3'd3;
    tick(); tick();
    check("rst_gnt", 8'(gnt), 8'h0);
    check("rst_sel", 8'(sel), 8'h0);
    check("rst_valid", 8'(valid), 8'h0);
    rst = 1'b0;

    // Single request from requester 1 held for three cycles.
    req = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("single_gnt", 8'(gnt), 8'h02);
      check("single_sel", 8'(sel), 8'h01);
      check("single_valid", 8'(valid), 8'h01);
      check("single_addr", 8'(addr_o), 8'h05);
    end
    req = 4'b0000;
    tick();
    check("single_drop_gnt", 8'(gnt), 8'h00);
    check("single_drop_valid", 8'(valid), 8'h00);
    check("single_drop_sel", 8'(sel), 8'h01);

    // Pointer fairness: grant 2, release, then 1011 must go to 3.
    req = 4'b0100;
    tick();
    check("fair_g2", 8'(gnt), 8'h04);
    req = 4'b0000;
    tick();
    check("fair_rel", 8'(gnt), 8'h00);
    req = 4'b1011;
    tick();
    check("fair_win3", 8'(gnt), 8'h08);
    check("fair_sel3", 8'(sel), 8'h03);
    check("fair_addr3", 8'(addr_o), 8'h03);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("fair_hold3", 8'(gnt), 8'h08);
    end
    tick();
    check("fair_rot0", 8'(gnt), 8'h01);
    req = 4'b0000;
    tick();
    check("fair_idle", 8'(valid), 8'h00);

    // Round-robin rotation with all four requesting.
    do_reset();
    req = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        e = 4'b0001 << r;
        check("rot_gnt", 8'(gnt), 8'(e));
        check("rot_valid", 8'(valid), 8'h01);
      end
      case (r)
        0: check("rot_addr", 8'(addr_o), 8'h02);
        1: check("rot_addr", 8'(addr_o), 8'h05);
        2: check("rot_addr", 8'(addr_o), 8'h06);
        default: check("rot_addr", 8'(addr_o), 8'h03);
      endcase
    end
    tick();
    check("rot_wrap", 8'(gnt), 8'h01);

    // Early release handover without a bubble.
    do_reset();
    req = 4'b0101;
    tick();
    check("early_g0a", 8'(gnt), 8'h01);
    tick();
    check("early_g0b", 8'(gnt), 8'h01);
    req = 4'b0100;
    tick();
    check("early_g2", 8'(gnt), 8'h04);
    check("early_valid", 8'(valid), 8'h01);
    check("early_sel", 8'(sel), 8'h02);

    // Sole requester times out and is regranted continuously.
    do_reset();
    req = 4'b1000;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("sole_gnt", 8'(gnt), 8'h08);
      check("sole_valid", 8'(valid), 8'h01);
      check("sole_hold", 8'(dut.hold_cnt), 8'((c % 4) + 1));
    end

    // Reset two cycles into requester 1's tenure.
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 6; c++) tick();
    check("mid_pre_gnt", 8'(gnt), 8'h02);
    rst = 1'b1;
    tick();
    check("mid_rst_gnt", 8'(gnt), 8'h00);
    check("mid_rst_valid", 8'(valid), 8'h00);
    check("mid_rst_sel", 8'(sel), 8'h00);
    rst = 1'b0;
    tick();
    check("mid_restart_gnt", 8'(gnt), 8'h01);
    check("mid_restart_sel", 8'(sel), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
